// File: rtl/dm_cache_wb.sv
// dm_cache_wb: direct-mapped, write-back, write-allocate data cache with
// multi-word lines between the load/store unit and main memory.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   cpu_req_i      request strobe, sampled only while idle
//   cpu_we_i       1 = store, 0 = load
//   cpu_addr_i     byte address (bits [1:0] ignored)
//   cpu_wdata_i    store data
//   cpu_rdata_o    load data, valid with cpu_done_o, held until the next done
//   cpu_done_o     one-cycle completion pulse
//   mem_req_o      memory beat request
//   mem_we_o       1 = write-back beat, 0 = refill beat
//   mem_addr_o     word-aligned beat address
//   mem_wdata_o    write-back data
//   mem_rdata_i    refill data, sampled on the ack edge
//   mem_ack_i      beat completes on an edge with mem_req_o & mem_ack_i
//   hit_cnt_o      first-lookup hit counter (wraps)
//   miss_cnt_o     first-lookup miss counter (wraps)
module dm_cache_wb #(
   parameter int unsigned BLOCKS = 2048,
   parameter int unsigned WORDS  = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_done_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);

   localparam int unsigned WW = $clog2(WORDS);
   localparam int unsigned WB = (WW == 0) ? 1 : WW;
   localparam int unsigned IB = $clog2(BLOCKS);
   localparam int unsigned OB = 2 + WW;
   localparam int unsigned TB = 32 - OB - IB;
   localparam int unsigned AW = $clog2(BLOCKS * WORDS);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COMPARE   = 2'd1,
      S_WRITEBACK = 2'd2,
      S_REFILL    = 2'd3
   } state_e;

   state_e              state_q;
   logic                we_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic                retry_q;
   logic [WB-1:0]       beat_q;
   logic [BLOCKS-1:0]   valid_q;
   logic [BLOCKS-1:0]   dirty_q;
   logic [31:0]         cpu_rdata_q;
   logic                cpu_done_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [31:0]         mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [31:0]         hit_q;
   logic [31:0]         miss_q;

   // Data and tag storage carry no reset; valid gates every use of them.
   logic [31:0]         data_q [BLOCKS*WORDS];
   logic [TB-1:0]       tag_q  [BLOCKS];

   logic [TB-1:0]       tag_c;
   logic [IB-1:0]       idx_c;
   logic [WB-1:0]       word_c;
   logic                hit_c;
   logic                beat_done_c;
   logic                last_beat_c;
   logic [WB-1:0]       beat_nxt_c;
   logic                data_we_c;
   logic [AW-1:0]       data_wa_c;
   logic [31:0]         data_wd_c;
   logic                tag_we_c;

   // Flat data-array index for word w of line i.
   function automatic logic [AW-1:0] dix(input logic [IB-1:0] i, input logic [WB-1:0] w);
      return AW'((32'(i) << WW) | 32'(w));
   endfunction

   // Word-aligned memory address of beat b of the line with tag t at index i.
   function automatic logic [31:0] beat_addr(input logic [TB-1:0] t, input logic [IB-1:0] i,
                                             input logic [WB-1:0] b);
      return (32'(t) << (OB + IB)) | (32'(i) << OB) | (32'(b) << 2);
   endfunction

   // Address decode of the latched request and lookup result.
   always_comb begin
      tag_c       = TB'(addr_q >> (OB + IB));
      idx_c       = IB'(addr_q >> OB);
      word_c      = WB'((addr_q >> 2) & 32'(WORDS - 1));
      hit_c       = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
      beat_done_c = mem_req_q && mem_ack_i;
      last_beat_c = (beat_q == WB'(WORDS - 1));
      beat_nxt_c  = WB'(beat_q + 1'b1);
   end

   // Array write port: store hits and refill beats never coincide.
   always_comb begin
      data_we_c = 1'b0;
      data_wa_c = '0;
      data_wd_c = '0;
      tag_we_c  = 1'b0;
      if (state_q == S_COMPARE && hit_c && we_q) begin
         data_we_c = 1'b1;
         data_wa_c = dix(idx_c, word_c);
         data_wd_c = wdata_q;
      end else if (state_q == S_REFILL && beat_done_c) begin
         data_we_c = 1'b1;
         data_wa_c = dix(idx_c, beat_q);
         data_wd_c = mem_rdata_i;
         tag_we_c  = last_beat_c;
      end
   end

   // Unreset storage arrays.
   always_ff @(posedge clk_i) begin
      if (data_we_c) data_q[data_wa_c] <= data_wd_c;
      if (tag_we_c)  tag_q[idx_c]      <= tag_c;
   end

   // Controller FSM with registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         retry_q     <= 1'b0;
         beat_q      <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         cpu_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         cpu_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_req_i) begin
                  we_q    <= cpu_we_i;
                  addr_q  <= cpu_addr_i;
                  wdata_q <= cpu_wdata_i;
                  retry_q <= 1'b0;
                  state_q <= S_COMPARE;
               end
            end

            S_COMPARE: begin
               // Only the first lookup of a request is counted.
               if (!retry_q) begin
                  if (hit_c) hit_q  <= hit_q + 32'd1;
                  else       miss_q <= miss_q + 32'd1;
               end
               if (hit_c) begin
                  cpu_done_q <= 1'b1;
                  if (we_q) dirty_q[idx_c] <= 1'b1;
                  else      cpu_rdata_q    <= data_q[dix(idx_c, word_c)];
                  state_q <= S_IDLE;
               end else begin
                  retry_q   <= 1'b1;
                  beat_q    <= '0;
                  mem_req_q <= 1'b1;
                  if (valid_q[idx_c] && dirty_q[idx_c]) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= beat_addr(tag_q[idx_c], idx_c, '0);
                     mem_wdata_q <= data_q[dix(idx_c, '0)];
                     state_q     <= S_WRITEBACK;
                  end else begin
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= beat_addr(tag_c, idx_c, '0);
                     state_q    <= S_REFILL;
                  end
               end
            end

            S_WRITEBACK: begin
               if (beat_done_c) begin
                  if (last_beat_c) begin
                     // mem_req stays high straight into the refill burst.
                     dirty_q[idx_c] <= 1'b0;
                     beat_q         <= '0;
                     mem_we_q       <= 1'b0;
                     mem_addr_q     <= beat_addr(tag_c, idx_c, '0);
                     state_q        <= S_REFILL;
                  end else begin
                     beat_q      <= beat_nxt_c;
                     mem_addr_q  <= beat_addr(tag_q[idx_c], idx_c, beat_nxt_c);
                     mem_wdata_q <= data_q[dix(idx_c, beat_nxt_c)];
                  end
               end
            end

            S_REFILL: begin
               if (beat_done_c) begin
                  if (last_beat_c) begin
                     valid_q[idx_c] <= 1'b1;
                     dirty_q[idx_c] <= 1'b0;
                     beat_q         <= '0;
                     mem_req_q      <= 1'b0;
                     state_q        <= S_COMPARE;
                  end else begin
                     beat_q     <= beat_nxt_c;
                     mem_addr_q <= beat_addr(tag_c, idx_c, beat_nxt_c);
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign cpu_done_o  = cpu_done_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign hit_cnt_o   = hit_q;
   assign miss_cnt_o  = miss_q;

endmodule

// File: tb/tb_dm_cache_wb.sv
// tb_dm_cache_wb: directed bench for dm_cache_wb (BLOCKS=16, WORDS=4).
// Stimulus pushes expected CPU completions and memory beats into queues;
// independent monitors pop and compare as the DUT presents them.
module tb_dm_cache_wb;

   localparam int unsigned BLOCKS = 16;
   localparam int unsigned WORDS  = 4;

   typedef struct {
      logic [31:0] rdata;
      logic        chk;
      int          lat;
      logic [31:0] hits;
      logic [31:0] misses;
   } cpu_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   logic        clk;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack   = 1'b0;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;
   int req_cycle   = 0;
   int ack_delay   = 0;
   int stall_cnt   = 0;
   logic prev_done = 1'b0;

   cpu_exp_t exp_cpu[$];
   mem_exp_t exp_mem[$];

   dm_cache_wb #(.BLOCKS(BLOCKS), .WORDS(WORDS)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .cpu_done_o  (cpu_done),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .mem_ack_i   (mem_ack),
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory model: data word = its own address; ack after ack_delay stalled cycles.
   always @(negedge clk) begin
      if (mem_req) begin
         if (exp_mem.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mem_unexpected: got beat at 0x%08h, expected no memory traffic", mem_addr);
            mem_ack   = 1'b1;
            mem_rdata = mem_addr;
         end else begin
            check("mem_we", 32'(mem_we), 32'(exp_mem[0].we));
            check("mem_addr", mem_addr, exp_mem[0].addr);
            if (exp_mem[0].we) check("mem_wdata", mem_wdata, exp_mem[0].wdata);
            if (stall_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_addr;
               stall_cnt = 0;
               exp_mem.pop_front();
            end else begin
               mem_ack = 1'b0;
               stall_cnt++;
            end
         end
      end else begin
         // With a zero-delay memory the ack is simply tied high.
         mem_ack   = (ack_delay == 0);
         mem_rdata = 32'hBAD0_0000;
         stall_cnt = 0;
      end
   end

   // CPU-side monitor.
   always @(negedge clk) begin
      cpu_exp_t e;
      if (cpu_done) begin
         check("done_single_pulse", 32'(prev_done), 32'd0);
         if (exp_cpu.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cpu_unexpected_done: got done, expected none (rdata 0x%08h)", cpu_rdata);
         end else begin
            e = exp_cpu.pop_front();
            if (e.chk) check("cpu_rdata", cpu_rdata, e.rdata);
            check("latency", 32'(cycle - req_cycle), 32'(e.lat));
            check("hit_cnt", hit_cnt, e.hits);
            check("miss_cnt", miss_cnt, e.misses);
         end
      end
      prev_done = cpu_done;
   end

   task automatic push_refill(input logic [31:0] base);
      mem_exp_t m;
      for (int i = 0; i < int'(WORDS); i++) begin
         m.we    = 1'b0;
         m.addr  = base + 32'(4 * i);
         m.wdata = 32'h0;
         exp_mem.push_back(m);
      end
   endtask

   task automatic push_wb(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
      mem_exp_t m;
      m.we = 1'b1;
      m.addr = base;          m.wdata = w0; exp_mem.push_back(m);
      m.addr = base + 32'd4;  m.wdata = w1; exp_mem.push_back(m);
      m.addr = base + 32'd8;  m.wdata = w2; exp_mem.push_back(m);
      m.addr = base + 32'd12; m.wdata = w3; exp_mem.push_back(m);
   endtask

   // Issue one request (called at a negedge) and wait, bounded, for done.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic chk, input logic [31:0] exp_rd, input int lat,
                         input logic [31:0] eh, input logic [31:0] em);
      cpu_exp_t e;
      int n;
      e.rdata = exp_rd; e.chk = chk; e.lat = lat; e.hits = eh; e.misses = em;
      exp_cpu.push_back(e);
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_req   = 1'b1;
      @(posedge clk);
      #1;
      req_cycle = cycle;
      cpu_req   = 1'b0;
      cpu_we    = ~we;
      cpu_addr  = 32'hFFFF_FFF0;
      cpu_wdata = 32'hA5A5_A5A5;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_done && n < 200);
      if (!cpu_done) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: got no done for 0x%08h, expected done within 200 cycles", addr);
         exp_cpu.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_done"}, 32'(cpu_done), 32'd0);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
      check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      ack_delay = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Cold read miss, then a hit in the same line.
      push_refill(32'h40);
      access(1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 6, 32'd0, 32'd1);
      access(1'b0, 32'h44, 32'h0, 1'b1, 32'h44, 1, 32'd1, 32'd1);

      // Store hit dirties line 4, then a conflicting load evicts it.
      access(1'b1, 32'h48, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 32'd2, 32'd1);
      push_wb(32'h40, 32'h40, 32'h44, 32'hDEAD_BEEF, 32'h4C);
      push_refill(32'h140);
      access(1'b0, 32'h148, 32'h0, 1'b1, 32'h148, 10, 32'd2, 32'd2);

      // Slow memory: ack every 4th cycle.
      ack_delay = 3;
      push_refill(32'h80);
      access(1'b0, 32'h80, 32'h0, 1'b1, 32'h80, 18, 32'd2, 32'd3);
      ack_delay = 0;

      // Write-allocate store, then hits on the allocated line.
      push_refill(32'hC0);
      access(1'b1, 32'hC4, 32'h1234_5678, 1'b0, 32'h0, 6, 32'd2, 32'd4);
      access(1'b0, 32'hC4, 32'h0, 1'b1, 32'h1234_5678, 1, 32'd3, 32'd4);
      access(1'b0, 32'hC8, 32'h0, 1'b1, 32'hC8, 1, 32'd4, 32'd4);
      access(1'b0, 32'h14C, 32'h0, 1'b1, 32'h14C, 1, 32'd5, 32'd4);

      // Reset asserted while refill beat 2 is outstanding.
      ack_delay = 3;
      push_refill(32'h200);
      cpu_we   = 1'b0;
      cpu_addr = 32'h200;
      cpu_req  = 1'b1;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mem_req && mem_addr == 32'h208) && n < 100);
      check("reach_refill_beat2", mem_addr, 32'h208);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_mem.delete();
      ack_delay = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Valid bits were cleared, so 0x40 misses and refills again.
      push_refill(32'h40);
      access(1'b0, 32'h40, 32'h0, 1'b1, 32'h40, 6, 32'd0, 32'd1);

      repeat (3) @(negedge clk);
      check("mem_beats_outstanding", 32'(exp_mem.size()), 32'd0);
      check("cpu_done_outstanding", 32'(exp_cpu.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dm_cache_wb.md
# dm_cache_wb

Parametrised direct-mapped, write-back, write-allocate data cache with multi-word lines, sitting between the core's load/store unit and main memory. It replaces the fixed-latency, single-word, byte-lane cache with two explicit handshakes: a request/done pulse interface on the CPU side and a req/ack burst interface on the memory side. Any memory latency is supported. The block also keeps hit and miss counters.

## Interface
- BLOCKS, 2048: number of lines; power of two, ≥2.
- WORDS, 1: 32-bit words per line; power of two, ≥1.
- Address split: offset = addr[OB-1:0] with OB = 2+log2(WORDS); index = addr[OB+log2(BLOCKS)-1:OB]; tag = remaining upper bits. addr[1:0] ignored.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid while cpu_done=1, holds until next done.
- cpu_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write-back beat, 0 = refill beat.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  refill data, sampled on ack edge.
- mem_ack  in  1  beat completes on edge with mem_req & mem_ack.
- hit_cnt  out  32  first-lookup hits, wraps.
- miss_cnt  out  32  first-lookup misses, wraps.

## Operation
- Storage: data[BLOCKS][WORDS], tag[BLOCKS], valid[BLOCKS], dirty[BLOCKS]. Data and tag arrays are not reset.
- Reset (asserted): FSM=IDLE; all valid=0 and all dirty=0; cpu_done, mem_req, mem_we=0; cpu_rdata, mem_addr, mem_wdata=0; counters=0. Takes effect immediately, mid-burst included; dirty data is discarded.
- IDLE: on cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, clear the retry flag, and go to COMPARE. CPU inputs are ignored outside IDLE.
- COMPARE: hit = valid[idx] & tag[idx]==latched tag.
  - Hit on a load: cpu_rdata = data[idx][word]. cpu_done pulses. Go to IDLE.
  - Hit on a store: write the word, set dirty[idx]=1, pulse cpu_done, go to IDLE.
  - Miss with valid & dirty: go to WRITEBACK, beat 0.
  - Miss otherwise: go to REFILL, beat 0.
  - hit_cnt or miss_cnt increments only when the retry flag is 0. The flag is set on leaving COMPARE on a miss, so the post-refill hit is not counted.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr = {old tag, idx, beat, 2'b00}, mem_wdata = data[idx][beat]. Each ack advances the beat. After the last ack, clear dirty[idx] and go to REFILL, beat 0.
- REFILL: mem_req=1, mem_we=0, mem_addr = {new tag, idx, beat, 2'b00}. Each ack writes mem_rdata into data[idx][beat]. After the last ack, set tag[idx]=new tag, valid[idx]=1, dirty[idx]=0, and return to COMPARE. That lookup is guaranteed to hit; the store, if any, is applied there.
- The beat counter is log2(WORDS) bits, minimum 1, and counts 0..WORDS-1.

## Timing
- mem_req, mem_we, mem_addr and mem_wdata are registered. They stay stable while mem_req=1 and mem_ack=0.
- mem_req stays high across consecutive beats and across the WRITEBACK→REFILL boundary. It drops on the edge that completes the last refill beat.
- mem_ack while mem_req=0 is ignored.
- Latency, counted from the edge N at which cpu_req is sampled, with mem_ack tied to 1:
  - Hit: cpu_done high after edge N+1.
  - Clean miss: cpu_done high after edge N+WORDS+2.
  - Dirty miss: cpu_done high after edge N+2·WORDS+2.
- Each cycle of ack delay adds one cycle.
- A new request can be sampled at the edge immediately after cpu_done falls (back-to-back hits: one every 2 cycles).
- cpu_done is never high for two consecutive cycles.

## Test plan
Configuration for all scenarios: BLOCKS=16, WORDS=4. The memory model returns word = its address, and ack is tied high unless stated otherwise.
- Cold read: reset, then load 0x40 → one refill burst at 0x40, 0x44, 0x48, 0x4C with mem_we=0 → cpu_rdata=0x40, done after N+6, miss_cnt=1, hit_cnt=0.
- Hit: load 0x44 after the cold read → no mem_req, cpu_rdata=0x44, done after N+1, hit_cnt=1.
- Dirty eviction: store 0xDEADBEEF to 0x48 (hit, no memory traffic), then load 0x148.
  - Write-back burst: 0x40..0x4C, wdata 0x40, 0x44, 0xDEADBEEF, 0x4C.
  - Refill burst: 0x140..0x14C.
  - Result: cpu_rdata=0x148, done after N+10, miss_cnt incremented by exactly 1.
- Slow memory: ack asserted every 4th cycle on a clean miss at 0x80 → mem_addr is stable for 3 stalled cycles per beat, done after N+18, cpu_rdata=0x80.
- Write-allocate: store 0x12345678 to invalid line 0xC4 → refill 0xC0..0xCC, then the store. A following load of 0xC4 hits and returns 0x12345678; a load of 0xC8 hits and returns 0xC8.
- Reset mid-refill: assert reset during refill beat 2 → mem_req goes to 0 immediately and all outputs take their reset values. After release, load 0x40 misses and refills again.
